// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard controller beside the ID stage: a combinational EX-stage check plus a
// per-register countdown scoreboard that covers loads with multi-cycle memory latency.
module load_hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_ex_memread,
    input  logic              id_ex_valid,
    input  logic [REG_AW-1:0] id_ex_rt,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              if_id_use_rs,
    input  logic              if_id_use_rt,
    input  logic              flush,
    input  logic              stall_cnt_clr,
    output logic              stall,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int NREG = 2 ** REG_AW;
    localparam int PW   = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
    localparam logic [PW-1:0] RELOAD = PW'(LOAD_LAT - 1);

    logic [PW-1:0]    pend_q [NREG];
    logic [PW-1:0]    pend_d [NREG];
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;

    logic load_issue;
    logic ex_hazard;
    logic sb_hazard;

    assign load_issue = id_ex_valid & id_ex_memread & (id_ex_rt != '0);

    always_comb begin
        ex_hazard = load_issue &
                    ((if_id_use_rs & (id_ex_rt == if_id_rs)) |
                     (if_id_use_rt & (id_ex_rt == if_id_rt)));
        sb_hazard = (if_id_use_rs & (pend_q[if_id_rs] != '0)) |
                    (if_id_use_rt & (pend_q[if_id_rt] != '0));
        stall     = (ex_hazard | sb_hazard) & ~flush;
    end

    assign pc_write     = ~stall;
    assign if_id_write  = ~stall;
    assign id_ex_bubble = stall;
    assign stall_count  = stall_count_q;

    // A fresh load to a register overrides that register's countdown; r0 never pends.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend_d[r] = pend_q[r];
            if (pend_q[r] != '0) begin
                pend_d[r] = pend_q[r] - PW'(1);
            end
        end
        if (load_issue) begin
            pend_d[id_ex_rt] = RELOAD;
        end
        pend_d[0] = '0;
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_cnt_clr) begin
            stall_count_d = '0;
        end else if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= pend_d[r];
            end
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Bench for load_hazard_scoreboard: two instances (LOAD_LAT=1/CNT_W=16 and LOAD_LAT=3/CNT_W=4)
// share one stimulus stream and are compared against a ready-time reference model.
module tb_load_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_ex_memread, id_ex_valid;
    logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
    logic       if_id_use_rs, if_id_use_rt, flush, stall_cnt_clr;

    logic        stall1, pcw1, ifw1, bub1;
    logic [15:0] cnt_o1;
    logic        stall3, pcw3, ifw3, bub3;
    logic [3:0]  cnt_o3;

    int checks = 0;
    int errors = 0;

    // Reference model: absolute cycle at which each register's load data becomes forwardable.
    longint cyc = 0;
    longint ready1 [32];
    longint ready3 [32];
    int     cnt1 = 0;
    int     cnt3 = 0;
    bit     e1, e3;

    always #5 clk = ~clk;

    load_hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .id_ex_memread(id_ex_memread), .id_ex_valid(id_ex_valid), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .if_id_use_rs(if_id_use_rs), .if_id_use_rt(if_id_use_rt),
        .flush(flush), .stall_cnt_clr(stall_cnt_clr),
        .stall(stall1), .pc_write(pcw1), .if_id_write(ifw1), .id_ex_bubble(bub1),
        .stall_count(cnt_o1)
    );

    load_hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) u_l3 (
        .clk(clk), .rst_n(rst_n),
        .id_ex_memread(id_ex_memread), .id_ex_valid(id_ex_valid), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .if_id_use_rs(if_id_use_rs), .if_id_use_rt(if_id_use_rt),
        .flush(flush), .stall_cnt_clr(stall_cnt_clr),
        .stall(stall3), .pc_write(pcw3), .if_id_write(ifw3), .id_ex_bubble(bub3),
        .stall_count(cnt_o3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit mr, input bit v, input int rt_ex, input int rs, input int rt,
                          input bit urs, input bit urt, input bit fl, input bit clr);
        id_ex_memread = mr;
        id_ex_valid   = v;
        id_ex_rt      = 5'(rt_ex);
        if_id_rs      = 5'(rs);
        if_id_rt      = 5'(rt);
        if_id_use_rs  = urs;
        if_id_use_rt  = urt;
        flush         = fl;
        stall_cnt_clr = clr;
    endtask

    function automatic bit model_stall(input int lat);
        bit issue, ex_t, sb_t;
        issue = id_ex_memread && id_ex_valid && (id_ex_rt != 0);
        ex_t  = issue && ((if_id_use_rs && id_ex_rt == if_id_rs) ||
                          (if_id_use_rt && id_ex_rt == if_id_rt));
        if (lat == 1)
            sb_t = (if_id_use_rs && ready1[if_id_rs] > cyc) || (if_id_use_rt && ready1[if_id_rt] > cyc);
        else
            sb_t = (if_id_use_rs && ready3[if_id_rs] > cyc) || (if_id_use_rt && ready3[if_id_rt] > cyc);
        return (ex_t || sb_t) && !flush;
    endfunction

    // Compare every output of both instances against the model, away from the rising edge.
    task automatic sample();
        @(negedge clk);
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                ready1[r] = 0;
                ready3[r] = 0;
            end
            cnt1 = 0;
            cnt3 = 0;
        end
        e1 = model_stall(1);
        e3 = model_stall(3);
        chk("l1_stall", 32'(stall1), 32'(e1));
        chk("l1_pc_write", 32'(pcw1), 32'(!e1));
        chk("l1_if_id_write", 32'(ifw1), 32'(!e1));
        chk("l1_bubble", 32'(bub1), 32'(e1));
        chk("l1_count", 32'(cnt_o1), 32'(cnt1));
        chk("l3_stall", 32'(stall3), 32'(e3));
        chk("l3_pc_write", 32'(pcw3), 32'(!e3));
        chk("l3_if_id_write", 32'(ifw3), 32'(!e3));
        chk("l3_bubble", 32'(bub3), 32'(e3));
        chk("l3_count", 32'(cnt_o3), 32'(cnt3));
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) begin
            if (stall_cnt_clr) cnt1 = 0;
            else if (e1 && cnt1 < 65535) cnt1++;
            if (stall_cnt_clr) cnt3 = 0;
            else if (e3 && cnt3 < 15) cnt3++;
            if (id_ex_memread && id_ex_valid && id_ex_rt != 0) begin
                ready1[id_ex_rt] = cyc + 1;
                ready3[id_ex_rt] = cyc + 3;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            ready1[r] = 0;
            ready3[r] = 0;
        end
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("reset_stall", 32'(stall3), 32'd0);
        chk("reset_count", 32'(cnt_o3), 32'd0);
        advance();
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();

        // Classic load-use: LOAD_LAT=1 stalls one cycle, LOAD_LAT=3 keeps going.
        set_in(1, 1, 5, 5, 0, 1, 0, 0, 0);
        sample(); chk("t1_l1_stall_t0", 32'(stall1), 32'd1); advance();
        set_in(0, 0, 0, 5, 0, 1, 0, 0, 0);
        sample(); chk("t1_l1_stall_t1", 32'(stall1), 32'd0); advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(); step();

        // Long latency on rt: three stall cycles, counter ends at 3.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_in(1, 1, 7, 0, 7, 0, 1, 0, 0);
        sample(); chk("t2_stall_c0", 32'(stall3), 32'd1); advance();
        set_in(0, 0, 0, 0, 7, 0, 1, 0, 0);
        sample(); chk("t2_stall_c1", 32'(stall3), 32'd1); advance();
        sample(); chk("t2_stall_c2", 32'(stall3), 32'd1); advance();
        sample(); chk("t2_stall_c3", 32'(stall3), 32'd0);
        chk("t2_count", 32'(cnt_o3), 32'd3); advance();

        // Register zero, unused source, unrelated register.
        set_in(1, 1, 0, 0, 0, 1, 1, 0, 0);
        sample(); chk("t3_r0", 32'(stall3), 32'd0); advance();
        set_in(1, 1, 4, 4, 0, 0, 0, 0, 0);
        sample(); chk("t3_unused", 32'(stall3), 32'd0); advance();
        set_in(1, 1, 4, 6, 0, 1, 0, 0, 0);
        sample(); chk("t3_indep", 32'(stall3), 32'd0); advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); step(); step();

        // Flush masks the stall but the scoreboard keeps counting.
        set_in(1, 1, 9, 9, 0, 1, 0, 0, 0);
        sample(); chk("t4_c0", 32'(stall3), 32'd1); advance();
        set_in(0, 0, 0, 9, 0, 1, 0, 1, 0);
        sample(); chk("t4_flush", 32'(stall3), 32'd0); advance();
        set_in(0, 0, 0, 9, 0, 1, 0, 0, 0);
        sample(); chk("t4_new_dep", 32'(stall3), 32'd1); advance();
        sample(); chk("t4_done", 32'(stall3), 32'd0); advance();

        // Back-to-back loads to r3 restart the count.
        set_in(1, 1, 3, 0, 0, 0, 0, 0, 0);
        step(); step();
        set_in(0, 0, 0, 3, 0, 1, 0, 0, 0);
        sample(); chk("t5_c2", 32'(stall3), 32'd1); advance();
        sample(); chk("t5_c3", 32'(stall3), 32'd1); advance();
        sample(); chk("t5_c4", 32'(stall3), 32'd0); advance();

        // Reset in the middle of a stall clears all pending state.
        set_in(1, 1, 11, 11, 0, 1, 0, 0, 0);
        step();
        set_in(0, 0, 0, 11, 0, 1, 0, 0, 0);
        step();
        rst_n = 1'b0;
        set_in(0, 0, 0, 11, 0, 1, 0, 0, 0);
        sample(); chk("t6_rst_stall", 32'(stall3), 32'd0);
        chk("t6_rst_count", 32'(cnt_o3), 32'd0); advance();
        rst_n = 1'b1;
        sample(); chk("t6_after_rst", 32'(stall3), 32'd0); advance();

        // Drive the 4-bit counter into saturation, then clear it.
        set_in(1, 1, 5, 5, 0, 1, 0, 0, 0);
        for (int i = 0; i < 18; i++) step();
        sample(); chk("t6_sat", 32'(cnt_o3), 32'd15); advance();
        set_in(1, 1, 5, 5, 0, 1, 0, 0, 1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        sample(); chk("t6_clr", 32'(cnt_o3), 32'd0); advance();

        // Randomised traffic over a small register window so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                set_in(0, 0, 0, $urandom_range(0, 7), $urandom_range(0, 7), 1, 1, 0, 0);
            end else begin
                rst_n = 1'b1;
                set_in($urandom_range(0, 1) == 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
